// File: rtl/ro_pkg.sv
// Shared types and helpers for the ring-oscillator scan controller.
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    REPORT
  } ro_scan_state_t;

  // Index width that stays legal even for a single-entry bank.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous oscillator output, detects rising edges and
// counts them into a saturating counter.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             async_in,
  output logic [CNT_W-1:0] count
);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] count_q;

  // The edge register keeps tracking while counting is off, so the first
  // enabled cycle compares against a real previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clr) begin
        count_q <= '0;
      end else if (cnt_en && sync2_q && !prev_q && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ro_scan_ctrl.sv
// Scans a ring-oscillator bank one channel at a time: settle, gate-count,
// report, and raise a sticky alarm on counts outside [thresh_lo, thresh_hi].
module ro_scan_ctrl
  import ro_pkg::*;
#(
  parameter int unsigned N_RO          = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  localparam int unsigned IDX_W        = clog2_min1(N_RO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             alarm_clr,
  input  logic [CNT_W-1:0] thresh_lo,
  input  logic [CNT_W-1:0] thresh_hi,
  input  logic [N_RO-1:0]  ro_in,
  output logic [N_RO-1:0]  ro_en,
  output logic             busy,
  output logic             result_valid,
  output logic [IDX_W-1:0] result_idx,
  output logic [CNT_W-1:0] result_count,
  output logic             alarm,
  output logic [IDX_W-1:0] alarm_idx
);

  localparam int unsigned MAXLEN = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(MAXLEN);

  ro_scan_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [N_RO-1:0]  ro_en_q, ro_en_d;
  logic             busy_q;
  logic             result_valid_q;
  logic [IDX_W-1:0] result_idx_q;
  logic [CNT_W-1:0] result_count_q;
  logic             alarm_q;
  logic [IDX_W-1:0] alarm_idx_q;
  logic [CNT_W-1:0] count;
  logic             trip;

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == SETTLE),
    .cnt_en   (state_q == GATE),
    .async_in (ro_in[idx_q]),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          ph_d    = '0;
        end
      end
      SETTLE: begin
        if (ph_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = GATE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      GATE: begin
        if (ph_q == PH_W'(GATE_CYCLES - 1)) begin
          state_d = REPORT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      REPORT: begin
        ph_d = '0;
        if (idx_q == IDX_W'(N_RO - 1)) begin
          idx_d   = '0;
          state_d = continuous ? SETTLE : IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables are decoded from the next state so the registered copy lines up
  // with the state the FSM is actually in.
  always_comb begin
    ro_en_d = '0;
    if ((state_d == SETTLE) || (state_d == GATE)) begin
      ro_en_d[idx_d] = 1'b1;
    end
  end

  assign trip = (count < thresh_lo) || (count > thresh_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      ph_q           <= '0;
      ro_en_q        <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      result_count_q <= '0;
      alarm_q        <= 1'b0;
      alarm_idx_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ph_q           <= ph_d;
      ro_en_q        <= ro_en_d;
      busy_q         <= (state_d != IDLE);
      result_valid_q <= (state_q == REPORT);
      if (state_q == REPORT) begin
        result_idx_q   <= idx_q;
        result_count_q <= count;
      end
      if ((state_q == REPORT) && trip) begin
        alarm_q <= 1'b1;
        if (!alarm_q) begin
          alarm_idx_q <= idx_q;
        end
      end else if (alarm_clr) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign ro_en        = ro_en_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_idx   = result_idx_q;
  assign result_count = result_count_q;
  assign alarm        = alarm_q;
  assign alarm_idx    = alarm_idx_q;

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed and randomized scans of ro_scan_ctrl against an edge-count and
// alarm model derived from oscillator periods and threshold rules.
module tb_ro_scan_ctrl;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int G    = 1024;
  localparam int S    = 16;
  localparam int GAP  = S + G + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, continuous, alarm_clr;
  logic [CW-1:0] thresh_lo, thresh_hi;
  logic [N-1:0]  ro_in;
  logic [N-1:0]  ro_en;
  logic          busy, result_valid, alarm;
  logic [1:0]    result_idx, alarm_idx;
  logic [CW-1:0] result_count;

  int n_assert = 0;
  int n_fail   = 0;
  int period[N];
  int phase[N];
  bit alarm_exp;
  int alarm_idx_exp;
  bit clr_arm;
  bit clr_hit;

  ro_scan_ctrl #(
    .N_RO          (N),
    .CNT_W         (CW),
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .alarm_clr    (alarm_clr),
    .thresh_lo    (thresh_lo),
    .thresh_hi    (thresh_hi),
    .ro_in        (ro_in),
    .ro_en        (ro_en),
    .busy         (busy),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .result_count (result_count),
    .alarm        (alarm),
    .alarm_idx    (alarm_idx)
  );

  always #5 clk = ~clk;

  // Square-wave oscillators; period 0 models a dead (stuck-low) oscillator.
  initial begin
    int unsigned cyc;
    cyc   = 0;
    ro_in = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < N; k++)
        ro_in[k] = (period[k] == 0) ? 1'b0 :
                   (((cyc + phase[k]) % period[k]) < (period[k] / 2));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Rising edges of a period-p square over G consecutive samples.
  function automatic void exp_range(input int p, output int lo, output int hi);
    if (p == 0) begin
      lo = 0;
      hi = 0;
    end else begin
      lo = G / p;
      hi = (G + p - 1) / p;
    end
    if (lo > MAXC) lo = MAXC;
    if (hi > MAXC) hi = MAXC;
  endfunction

  function automatic bit trips(input int c);
    return (c < int'(thresh_lo)) || (c > int'(thresh_hi));
  endfunction

  task automatic pick_thresh();
    bit ok;
    int lo, hi;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      thresh_lo = CW'($urandom_range(0, MAXC));
      thresh_hi = CW'($urandom_range(0, MAXC));
      ok = 1'b1;
      for (int k = 0; k < N; k++) begin
        exp_range(period[k], lo, hi);
        if (trips(lo) != trips(hi)) ok = 1'b0;
      end
    end
    if (!ok) begin
      thresh_lo = '0;
      thresh_hi = '1;
    end
  endtask

  task automatic wait_result(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < GAP + 60) begin
      @(negedge clk);
      alarm_clr = 1'b0;
      cyc++;
      chk("ro_en_onehot", ($onehot0(ro_en) && (busy || ro_en == '0)), 1);
      if (result_valid) begin
        got = 1'b1;
      end else if (clr_arm && busy && ro_en == '0) begin
        alarm_clr = 1'b1;
        clr_hit   = 1'b1;
      end
    end
  endtask

  task automatic measure(input int k, input int gap);
    bit got;
    int cyc, lo, hi;
    wait_result(got, cyc);
    chk("result_seen", got, 1);
    if (got) begin
      chk("result_spacing", cyc, gap);
      chk("result_idx", result_idx, k);
      exp_range(period[k], lo, hi);
      chk_range("result_count", result_count, lo, hi);
      if (trips(lo)) begin
        if (!alarm_exp) alarm_idx_exp = k;
        alarm_exp = 1'b1;
      end else if (clr_hit) begin
        alarm_exp = 1'b0;
      end
      clr_hit = 1'b0;
      chk("alarm", alarm, alarm_exp);
      chk("alarm_idx", alarm_idx, alarm_idx_exp);
    end
  endtask

  task automatic start_scan();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ro_en_first", ro_en, 1);
  endtask

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; alarm_clr = 1'b0;
    thresh_lo = '0; thresh_hi = '1;
    clr_arm = 1'b0; clr_hit = 1'b0; alarm_exp = 1'b0; alarm_idx_exp = 0;
    set_periods(8, 16, 32, 64);
    for (int k = 0; k < N; k++) phase[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_idx", result_idx, 0);
    chk("rst_result_count", result_count, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_alarm_idx", alarm_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single scan, with a start pulse during SETTLE of idx1 that must be ignored.
    start_scan();
    measure(0, GAP);
    chk("ro_en_settle_idx1", ro_en, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    measure(1, GAP - 1);
    measure(2, GAP);
    measure(3, GAP);
    chk("busy_done", busy, 0);
    @(negedge clk);
    chk("result_valid_pulse", result_valid, 0);
    chk("result_count_hold", result_count, 16);

    // Alarm window; clear coincides with the idx3 trip.
    thresh_lo = 30; thresh_hi = 100;
    start_scan();
    measure(0, GAP);
    measure(1, GAP);
    measure(2, GAP);
    clr_arm = 1'b1;
    measure(3, GAP);
    clr_arm = 1'b0;
    @(negedge clk);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    alarm_exp = 1'b0;
    chk("alarm_cleared", alarm, 0);
    chk("alarm_idx_hold", alarm_idx, alarm_idx_exp);

    // Continuous scan with a dead oscillator and a saturating one.
    set_periods(0, 4, 32, 64);
    thresh_lo = 5; thresh_hi = 200;
    continuous = 1'b1;
    start_scan();
    for (int k = 0; k < N; k++) measure(k, GAP);
    chk("cont_busy", busy, 1);
    chk("cont_ro_en_idx0", ro_en, 1);
    measure(0, GAP);
    measure(1, GAP);
    continuous = 1'b0;
    measure(2, GAP);
    measure(3, GAP);
    chk("cont_stop_busy", busy, 0);

    // Reset 500 cycles into GATE of idx2.
    set_periods(8, 16, 32, 64);
    thresh_lo = '0; thresh_hi = '1;
    start_scan();
    measure(0, GAP);
    measure(1, GAP);
    repeat (S + 500) @(negedge clk);
    chk("gate_idx2_ro_en", ro_en, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    alarm_exp = 1'b0;
    alarm_idx_exp = 0;
    chk("mid_rst_ro_en", ro_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result_valid", result_valid, 0);
    chk("mid_rst_result_idx", result_idx, 0);
    chk("mid_rst_result_count", result_count, 0);
    chk("mid_rst_alarm", alarm, 0);
    seen = 1'b0;
    repeat (G) begin
      @(negedge clk);
      if (result_valid || busy) seen = 1'b1;
    end
    chk("no_activity_after_rst", seen, 0);
    start_scan();
    measure(0, GAP);
    measure(1, GAP);
    measure(2, GAP);
    measure(3, GAP);

    // Randomized periods, phases, thresholds and clear timing.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        period[k] = ($urandom_range(0, 7) == 0) ? 0 : 4 + 2 * $urandom_range(0, 33);
        phase[k]  = $urandom_range(0, 63);
      end
      pick_thresh();
      @(negedge clk);
      start_scan();
      for (int k = 0; k < N; k++) begin
        clr_arm = 1'($urandom_range(0, 1));
        measure(k, GAP);
      end
      clr_arm = 1'b0;
      chk("rand_busy_done", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
